frame_validator: RTL and testbench
==================================

// Module: frame_validator
// PURPOSE
//  Downstream of serial_decode. Tracks Manchester bit strobes per transmission,
//  waits for a full 192-bit frame, and checks preamble, type, constant and tail
//  fields against expected values.
//  Good frames are latched into a held output buffer for the display path. Bad or
//  truncated frames are dropped and counted. The buffer only changes on a
//  verified frame.
// PARAMETERS
//  FRAME_BITS       192            bits per frame (sum of all decoded fields)
//  EXP_PREAMBLE     32'h5555_5555  required preamble value
//  EXP_TYPE         16'h0C0C       required value of both type_1 and type_2
//  EXP_CONSTANT     32'h0000_0001  required constant field
//  EXP_TAIL         8'h00          required value of tail_1, tail_2 and tail_3
//  TIMEOUT_CYCLES   4096           max clocks between strobes inside a frame
// PORTS
//  clock               in   1   system clock; all logic on posedge
//  reset               in   1   synchronous, active-high
//  transmission_begin  in   1   1-cycle pulse; new frame starts (serial_decode clears same edge)
//  bit_strobe          in   1   1-cycle pulse per decoded bit (manchester_clock edge)
//  preamble            in   32  live field from serial_decode
//  type_1, type_2      in   16  live fields
//  constant            in   32  live field
//  thermostat_id       in   32  live field
//  room_temp, set_temp in   16  live fields
//  state               in   8   live field
//  tail_1..tail_3      in   8   live fields
//  frame_valid         out  1   1-cycle pulse when the buffer is updated
//  have_frame          out  1   sticky; high once any good frame has been latched
//  held_id             out  32  last good thermostat_id
//  held_room, held_set out  16  last good room_temp and set_temp
//  held_state          out  8   last good state
//  good_count          out  8   saturating count of good frames
//  bad_count           out  8   saturating count of rejected frames
//  last_error          out  2   0 none, 1 field mismatch, 2 timeout, 3 restart
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, bit_cnt and idle_cnt are 0.
//  FSM has four states: IDLE, RECV, CHECK, COMMIT.
//   IDLE:   transmission_begin -> RECV, bit_cnt=0, idle_cnt=0. Strobes are ignored.
//   RECV:   bit_strobe -> bit_cnt+1 and idle_cnt=0; with no strobe, idle_cnt+1.
//           The strobe that makes bit_cnt==FRAME_BITS moves the FSM to CHECK on the next edge.
//           idle_cnt==TIMEOUT_CYCLES -> IDLE, bad_count+1, last_error=2.
//           transmission_begin -> stay in RECV and restart counters; bad_count+1,
//           last_error=3.
//   CHECK:  exactly 1 cycle. Evaluates all expected-field compares on the live inputs
//           and registers the result. Strobes are ignored.
//           Pass -> COMMIT. Fail -> IDLE, bad_count+1, last_error=1.
//           If transmission_begin arrives in CHECK, the check still uses this
//           cycle's inputs. Next state is then RECV with counters cleared, and a
//           pass still performs the commit in that same transition.
//   COMMIT: copies the inputs into held_* and sets frame_valid=1 for this cycle.
//           Also have_frame=1, good_count+1, last_error=0. Then -> IDLE.
//           transmission_begin here -> RECV.
//  Latency: frame_valid asserts 2 cycles after the final bit_strobe.
//  Counters saturate at 8'hFF and never wrap. idle_cnt saturates at TIMEOUT_CYCLES.
//  bit_cnt is $clog2(FRAME_BITS+1) wide.
//  held_* change only in COMMIT. A rejected frame never disturbs the buffer.
//  Reset mid-frame discards the partial frame, clears the buffer and does not count it.
//  transmission_begin and bit_strobe in the same cycle: begin wins and the strobe is dropped.
// STRUCTURE
//  Shared header frame_defs.vh holds: FRAME_BITS, the field widths, the state
//  encodings, and the ERR_NONE/ERR_FIELD/ERR_TIMEOUT/ERR_RESTART codes.
//  Sub-module sat_counter #(W) has ports clock, reset, inc, count; it is instanced
//  for good_count and bad_count.
//  The FSM, bit/idle counters and held buffer stay in this module.
// TESTING
//  1. Good frame: 192 strobes with all fields set to EXP_* and id=32'h1234_5678,
//     room=16'd215 -> frame_valid pulse 2 cycles after the last strobe,
//     held_id=32'h1234_5678, held_room=215, good_count=1, last_error=0.
//  2. Preamble 32'h5555_5554, everything else good -> no frame_valid, held_* unchanged,
//     bad_count=1, last_error=1.
//  3. 100 strobes then silence for TIMEOUT_CYCLES clocks -> IDLE, bad_count=1,
//     last_error=2. The next good frame still commits.
//  4. transmission_begin after 50 strobes, then a full good frame -> bad_count=1 with
//     last_error=3, then a commit with good_count=1 and last_error=0.
//  5. 300 good frames -> good_count holds at 8'hFF with no wrap.
//  6. Reset asserted during the strobe count -> all outputs 0 on the next cycle and
//     have_frame=0. transmission_begin coincident with the final CHECK -> the commit
//     still occurs and the FSM is in RECV.

Source files
------------

// File: rtl/frame_validator_pkg.sv
// Shared definitions for the frame validator: frame geometry, field widths,
// FSM state encodings and last_error codes.
package frame_validator_pkg;

  localparam int DEF_FRAME_BITS = 192;

  localparam int PREAMBLE_W = 32;
  localparam int TYPE_W     = 16;
  localparam int CONST_W    = 32;
  localparam int ID_W       = 32;
  localparam int TEMP_W     = 16;
  localparam int STATE_W    = 8;
  localparam int TAIL_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECV   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_COMMIT = 2'd3
  } fv_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_FIELD   = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_RESTART = 2'd3
  } err_code_t;

endpackage

// File: rtl/frame_validator_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/frame_validator.sv
// Counts bit strobes per transmission, checks the fixed fields of a full frame
// and latches good frames into a held buffer; bad or truncated frames are counted.
//
//  state     | meaning
//  ST_IDLE   | waiting for transmission_begin, strobes ignored
//  ST_RECV   | counting strobes, watching the inter-strobe timeout
//  ST_CHECK  | one cycle: compare fixed fields, commit buffer on pass
//  ST_COMMIT | frame_valid high, buffer holds the new frame
module frame_validator
  import frame_validator_pkg::*;
#(
  parameter int          FRAME_BITS     = DEF_FRAME_BITS,
  parameter logic [31:0] EXP_PREAMBLE   = 32'h5555_5555,
  parameter logic [15:0] EXP_TYPE       = 16'h0C0C,
  parameter logic [31:0] EXP_CONSTANT   = 32'h0000_0001,
  parameter logic [7:0]  EXP_TAIL       = 8'h00,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  transmission_begin,
  input  logic                  bit_strobe,
  input  logic [PREAMBLE_W-1:0] preamble,
  input  logic [TYPE_W-1:0]     type_1,
  input  logic [TYPE_W-1:0]     type_2,
  input  logic [CONST_W-1:0]    constant,
  input  logic [ID_W-1:0]       thermostat_id,
  input  logic [TEMP_W-1:0]     room_temp,
  input  logic [TEMP_W-1:0]     set_temp,
  input  logic [STATE_W-1:0]    state,
  input  logic [TAIL_W-1:0]     tail_1,
  input  logic [TAIL_W-1:0]     tail_2,
  input  logic [TAIL_W-1:0]     tail_3,
  output logic                  frame_valid,
  output logic                  have_frame,
  output logic [ID_W-1:0]       held_id,
  output logic [TEMP_W-1:0]     held_room,
  output logic [TEMP_W-1:0]     held_set,
  output logic [STATE_W-1:0]    held_state,
  output logic [7:0]            good_count,
  output logic [7:0]            bad_count,
  output logic [1:0]            last_error
);

  localparam int BIT_W  = $clog2(FRAME_BITS + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  fv_state_t         fsm_state;
  logic [BIT_W-1:0]  bit_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              fields_ok;
  logic              timeout_hit;
  logic              good_inc;
  logic              bad_inc;

  always_comb begin
    fields_ok   = (preamble == EXP_PREAMBLE) && (type_1 == EXP_TYPE) &&
                  (type_2 == EXP_TYPE) && (constant == EXP_CONSTANT) &&
                  (tail_1 == EXP_TAIL) && (tail_2 == EXP_TAIL) && (tail_3 == EXP_TAIL);
    timeout_hit = (fsm_state == ST_RECV) && !transmission_begin && !bit_strobe &&
                  (idle_cnt == IDLE_W'(TIMEOUT_CYCLES));
    good_inc    = (fsm_state == ST_CHECK) && fields_ok;
    bad_inc     = ((fsm_state == ST_RECV) && transmission_begin) || timeout_hit ||
                  ((fsm_state == ST_CHECK) && !fields_ok);
  end

  // The buffer is loaded on the CHECK exit edge so it captures exactly the
  // inputs that were compared, even when a new transmission starts that edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_state   <= ST_IDLE;
      bit_cnt     <= '0;
      idle_cnt    <= '0;
      frame_valid <= 1'b0;
      have_frame  <= 1'b0;
      held_id     <= '0;
      held_room   <= '0;
      held_set    <= '0;
      held_state  <= '0;
      last_error  <= ERR_NONE;
    end else begin
      frame_valid <= 1'b0;
      case (fsm_state)
        ST_IDLE: begin
          if (transmission_begin) begin
            fsm_state <= ST_RECV;
            bit_cnt   <= '0;
            idle_cnt  <= '0;
          end
        end
        ST_RECV: begin
          if (transmission_begin) begin
            bit_cnt    <= '0;
            idle_cnt   <= '0;
            last_error <= ERR_RESTART;
          end else if (bit_strobe) begin
            bit_cnt  <= bit_cnt + 1'b1;
            idle_cnt <= '0;
            if (bit_cnt == BIT_W'(FRAME_BITS - 1)) fsm_state <= ST_CHECK;
          end else if (timeout_hit) begin
            fsm_state  <= ST_IDLE;
            last_error <= ERR_TIMEOUT;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        ST_CHECK: begin
          if (fields_ok) begin
            held_id     <= thermostat_id;
            held_room   <= room_temp;
            held_set    <= set_temp;
            held_state  <= state;
            frame_valid <= 1'b1;
            have_frame  <= 1'b1;
            last_error  <= ERR_NONE;
            fsm_state   <= ST_COMMIT;
          end else begin
            last_error <= ERR_FIELD;
            fsm_state  <= ST_IDLE;
          end
          if (transmission_begin) begin
            fsm_state <= ST_RECV;
            bit_cnt   <= '0;
            idle_cnt  <= '0;
          end
        end
        ST_COMMIT: begin
          fsm_state <= transmission_begin ? ST_RECV : ST_IDLE;
          bit_cnt   <= '0;
          idle_cnt  <= '0;
        end
        default: fsm_state <= ST_IDLE;
      endcase
    end
  end

  sat_counter #(.W(8)) u_good_count (
    .clock (clock),
    .reset (reset),
    .inc   (good_inc),
    .count (good_count)
  );

  sat_counter #(.W(8)) u_bad_count (
    .clock (clock),
    .reset (reset),
    .inc   (bad_inc),
    .count (bad_count)
  );

endmodule

// File: tb/tb_frame_validator.sv
// Directed bench for frame_validator: field-check vector table plus hand-written
// timeout, restart, reset, coincident-begin and saturation sequences.
module tb_frame_validator;

  localparam int TIMEOUT = 4096;

  logic        clock = 1'b0;
  logic        reset;
  logic        transmission_begin;
  logic        bit_strobe;
  logic [31:0] preamble;
  logic [15:0] type_1, type_2;
  logic [31:0] constant;
  logic [31:0] thermostat_id;
  logic [15:0] room_temp, set_temp;
  logic [7:0]  state;
  logic [7:0]  tail_1, tail_2, tail_3;
  logic        frame_valid, have_frame;
  logic [31:0] held_id;
  logic [15:0] held_room, held_set;
  logic [7:0]  held_state, good_count, bad_count;
  logic [1:0]  last_error;

  always #5 clock = ~clock;

  frame_validator dut (
    .clock(clock), .reset(reset), .transmission_begin(transmission_begin),
    .bit_strobe(bit_strobe), .preamble(preamble), .type_1(type_1), .type_2(type_2),
    .constant(constant), .thermostat_id(thermostat_id), .room_temp(room_temp),
    .set_temp(set_temp), .state(state), .tail_1(tail_1), .tail_2(tail_2),
    .tail_3(tail_3), .frame_valid(frame_valid), .have_frame(have_frame),
    .held_id(held_id), .held_room(held_room), .held_set(held_set),
    .held_state(held_state), .good_count(good_count), .bad_count(bad_count),
    .last_error(last_error)
  );

  typedef struct {
    logic [31:0] pre;
    logic [15:0] t1, t2;
    logic [31:0] cst;
    logic [7:0]  tl1, tl2, tl3;
    logic [31:0] id;
    logic [15:0] room, setp;
    logic [7:0]  st;
    logic        ok;
    logic [1:0]  err;
  } vec_t;

  vec_t vecs[9];

  int checks   = 0;
  int failures = 0;

  int          exp_good, exp_bad;
  logic [31:0] exp_id;
  logic [15:0] exp_room, exp_set;
  logic [7:0]  exp_st;
  logic        exp_have;
  logic        got;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t good_vec(input logic [31:0] id, input logic [15:0] room,
                                    input logic [15:0] setp, input logic [7:0] st);
    vec_t v;
    v.pre = 32'h5555_5555; v.t1 = 16'h0C0C; v.t2 = 16'h0C0C; v.cst = 32'h0000_0001;
    v.tl1 = 8'h00; v.tl2 = 8'h00; v.tl3 = 8'h00;
    v.id = id; v.room = room; v.setp = setp; v.st = st;
    v.ok = 1'b1; v.err = 2'd0;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    preamble = v.pre; type_1 = v.t1; type_2 = v.t2; constant = v.cst;
    tail_1 = v.tl1; tail_2 = v.tl2; tail_3 = v.tl3;
    thermostat_id = v.id; room_temp = v.room; set_temp = v.setp; state = v.st;
  endtask

  task automatic pulse_begin();
    transmission_begin = 1'b1;
    tick();
    transmission_begin = 1'b0;
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      bit_strobe = 1'b1;
      tick();
    end
    bit_strobe = 1'b0;
  endtask

  // Called right after the final strobe: one CHECK cycle, then frame_valid.
  task automatic finish_frame(output logic fv, output logic early);
    early = frame_valid;
    tick();
    fv = frame_valid;
    tick();
  endtask

  task automatic commit_model();
    exp_good = (exp_good < 255) ? exp_good + 1 : 255;
    exp_have = 1'b1;
    exp_id = thermostat_id; exp_room = room_temp; exp_set = set_temp; exp_st = state;
  endtask

  task automatic check_buffer(input string tag);
    check({tag, "_held_id"}, held_id, exp_id);
    check({tag, "_held_room"}, {16'h0, held_room}, {16'h0, exp_room});
    check({tag, "_held_set"}, {16'h0, held_set}, {16'h0, exp_set});
    check({tag, "_held_state"}, {24'h0, held_state}, {24'h0, exp_st});
    check({tag, "_have_frame"}, {31'h0, have_frame}, {31'h0, exp_have});
    check({tag, "_good_count"}, {24'h0, good_count}, exp_good);
    check({tag, "_bad_count"}, {24'h0, bad_count}, exp_bad);
  endtask

  initial begin
    logic early;
    int   waited;
    vec_t v;

    vecs[0] = good_vec(32'h1234_5678, 16'd215, 16'd200, 8'h03);
    vecs[1] = good_vec(32'hAAAA_0001, 16'd180, 16'd190, 8'h01);
    vecs[1].pre = 32'h5555_5554; vecs[1].ok = 1'b0; vecs[1].err = 2'd1;
    vecs[2] = good_vec(32'hAAAA_0002, 16'd181, 16'd191, 8'h02);
    vecs[2].t1 = 16'h0C0D; vecs[2].ok = 1'b0; vecs[2].err = 2'd1;
    vecs[3] = good_vec(32'hAAAA_0003, 16'd182, 16'd192, 8'h04);
    vecs[3].t2 = 16'h8C0C; vecs[3].ok = 1'b0; vecs[3].err = 2'd1;
    vecs[4] = good_vec(32'hAAAA_0004, 16'd183, 16'd193, 8'h05);
    vecs[4].cst = 32'h0000_0000; vecs[4].ok = 1'b0; vecs[4].err = 2'd1;
    vecs[5] = good_vec(32'hAAAA_0005, 16'd184, 16'd194, 8'h06);
    vecs[5].tl1 = 8'h01; vecs[5].ok = 1'b0; vecs[5].err = 2'd1;
    vecs[6] = good_vec(32'hAAAA_0006, 16'd185, 16'd195, 8'h07);
    vecs[6].tl2 = 8'h80; vecs[6].ok = 1'b0; vecs[6].err = 2'd1;
    vecs[7] = good_vec(32'hAAAA_0007, 16'd186, 16'd196, 8'h08);
    vecs[7].tl3 = 8'hFF; vecs[7].ok = 1'b0; vecs[7].err = 2'd1;
    vecs[8] = good_vec(32'hCAFE_BEEF, 16'd222, 16'd210, 8'h11);

    reset = 1'b1; transmission_begin = 1'b0; bit_strobe = 1'b0;
    apply(vecs[0]);
    exp_good = 0; exp_bad = 0; exp_have = 1'b0;
    exp_id = '0; exp_room = '0; exp_set = '0; exp_st = '0;
    repeat (3) tick();
    check("reset_frame_valid", {31'h0, frame_valid}, 32'h0);
    check("reset_last_error", {30'h0, last_error}, 32'h0);
    check_buffer("reset");
    reset = 1'b0;
    tick();

    // Strobes while idle must not start a frame.
    strobes(200);
    tick();
    check("idle_strobes_no_fv", {31'h0, frame_valid}, 32'h0);
    check("idle_strobes_bad", {24'h0, bad_count}, 32'h0);

    for (int k = 0; k < 9; k++) begin
      apply(vecs[k]);
      pulse_begin();
      strobes(192);
      finish_frame(got, early);
      check($sformatf("vec%0d_fv_early", k), {31'h0, early}, 32'h0);
      check($sformatf("vec%0d_frame_valid", k), {31'h0, got}, {31'h0, vecs[k].ok});
      if (vecs[k].ok) commit_model();
      else exp_bad++;
      check($sformatf("vec%0d_last_error", k), {30'h0, last_error}, {30'h0, vecs[k].err});
      check_buffer($sformatf("vec%0d", k));
    end

    // Truncated frame then silence: timeout after TIMEOUT+1 silent cycles.
    v = good_vec(32'h0BAD_0001, 16'd100, 16'd101, 8'h21);
    apply(v);
    pulse_begin();
    strobes(100);
    waited = 0;
    while (bad_count == 8'(exp_bad) && waited < TIMEOUT + 100) begin
      tick();
      waited++;
    end
    exp_bad++;
    check("timeout_wait_cycles", waited, TIMEOUT + 1);
    check("timeout_last_error", {30'h0, last_error}, 32'd2);
    check_buffer("timeout");
    pulse_begin();
    strobes(192);
    finish_frame(got, early);
    commit_model();
    check("after_timeout_fv", {31'h0, got}, 32'h1);
    check("after_timeout_err", {30'h0, last_error}, 32'd0);
    check_buffer("after_timeout");

    // Restart after 50 strobes, then a full frame on the restarted count.
    v = good_vec(32'h0000_0050, 16'd150, 16'd151, 8'h31);
    apply(v);
    pulse_begin();
    strobes(50);
    pulse_begin();
    exp_bad++;
    check("restart_last_error", {30'h0, last_error}, 32'd3);
    check_buffer("restart");
    strobes(192);
    finish_frame(got, early);
    commit_model();
    check("restart_commit_fv", {31'h0, got}, 32'h1);
    check("restart_commit_err", {30'h0, last_error}, 32'd0);
    check_buffer("restart_commit");

    // Reset in the middle of the strobe count clears everything.
    pulse_begin();
    strobes(80);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_good = 0; exp_bad = 0; exp_have = 1'b0;
    exp_id = '0; exp_room = '0; exp_set = '0; exp_st = '0;
    check("midreset_fv", {31'h0, frame_valid}, 32'h0);
    check("midreset_err", {30'h0, last_error}, 32'h0);
    check_buffer("midreset");
    strobes(192);
    tick();
    tick();
    check("midreset_no_resume", {24'h0, good_count}, 32'h0);

    // Begin coincident with CHECK: commit happens and FSM lands in RECV.
    v = good_vec(32'h600D_0006, 16'd206, 16'd207, 8'h41);
    apply(v);
    pulse_begin();
    strobes(192);
    transmission_begin = 1'b1;
    tick();
    transmission_begin = 1'b0;
    commit_model();
    check("coinc_fv", {31'h0, frame_valid}, 32'h1);
    check_buffer("coinc");
    v = good_vec(32'h600D_0007, 16'd208, 16'd209, 8'h42);
    apply(v);
    strobes(192);
    finish_frame(got, early);
    commit_model();
    check("coinc_recv_fv", {31'h0, got}, 32'h1);
    check_buffer("coinc_recv");

    // Saturation of good_count.
    for (int n = 0; n < 300; n++) begin
      pulse_begin();
      strobes(192);
      finish_frame(got, early);
      commit_model();
    end
    check("sat_last_fv", {31'h0, got}, 32'h1);
    check("sat_good_count", {24'h0, good_count}, 32'hFF);
    check_buffer("sat");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
